// File: rtl/pc_sequencer.sv
// pc_sequencer: registered program counter for the word-addressed MIPS datapath.
// The next PC comes from one of these sources, in priority order:
//   jr > jal > jump > branch_taken > sequential
// Only the highest-priority request is accepted. Lower requests are dropped.
// A stall holds the PC and suppresses all side effects.
// Every accepted redirect produces a one-cycle flush on the following cycle.
// A circular return-address stack (RAS) predicts jr targets:
//   - jal pushes the link address; when full, the oldest entry is overwritten.
//   - jr pops, and raises ras_miss if the prediction was absent or wrong.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   stall                           hold PC, ignore all control inputs
//   jal, jump, jr, branch_taken     redirect requests
//   jump_index                      26-bit target index for jump/jal
//   jr_target, branch_offset        jr register value, sign-extended word offset
//   pc, pc_plus, next_pc            current PC, PC+1 (link address), selected next PC
//   flush                           registered pulse after an accepted redirect
//   ras_pred, ras_empty, ras_miss   RAS top (0 if empty), empty flag, mispredict pulse
//
// Optional feature (define PC_PERF_CNT_EN):
//   redirect_count, ras_miss_count  wrapping 32-bit event counters
module pc_sequencer #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int unsigned       RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              jal,
  input  logic              jump,
  input  logic              jr,
  input  logic              branch_taken,
  input  logic [25:0]       jump_index,
  input  logic [ADDR_W-1:0] jr_target,
  input  logic [ADDR_W-1:0] branch_offset,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus,
  output logic [ADDR_W-1:0] next_pc,
  output logic              flush,
  output logic [ADDR_W-1:0] ras_pred,
  output logic              ras_empty,
  output logic              ras_miss
`ifdef PC_PERF_CNT_EN
  ,
  output logic [31:0]       redirect_count,
  output logic [31:0]       ras_miss_count
`endif
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_SEQ,
    SEL_BRANCH,
    SEL_JUMP,
    SEL_JAL,
    SEL_JR
  } sel_e;

  sel_e sel;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              flush_q, flush_d;
  logic              ras_miss_q, ras_miss_d;
  logic [ADDR_W-1:0] ras_mem_q [RAS_DEPTH];
  logic [ADDR_W-1:0] ras_mem_d [RAS_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  ras_cnt_q, ras_cnt_d;

  logic [PTR_W-1:0]  top_idx;
  logic [ADDR_W-1:0] jump_target;
  logic              redirect;
  logic              push;
  logic              pop;

  assign pc_plus     = pc_q + ADDR_W'(1);
  assign jump_target = {pc_plus[ADDR_W-1:26], jump_index};

  // wr_ptr points at the next free slot, so the top of stack sits one below it.
  assign top_idx   = wr_ptr_q - PTR_W'(1);
  assign ras_empty = (ras_cnt_q == '0);
  assign ras_pred  = ras_empty ? '0 : ras_mem_q[top_idx];

  always_comb begin
    sel = SEL_SEQ;
    if (stall) begin
      sel = SEL_HOLD;
    end else if (jr) begin
      sel = SEL_JR;
    end else if (jal) begin
      sel = SEL_JAL;
    end else if (jump) begin
      sel = SEL_JUMP;
    end else if (branch_taken) begin
      sel = SEL_BRANCH;
    end
  end

  always_comb begin
    next_pc  = pc_plus;
    redirect = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    unique case (sel)
      SEL_HOLD:   next_pc = pc_q;
      SEL_SEQ:    next_pc = pc_plus;
      SEL_BRANCH: begin
        next_pc  = pc_plus + branch_offset;
        redirect = 1'b1;
      end
      SEL_JUMP: begin
        next_pc  = jump_target;
        redirect = 1'b1;
      end
      SEL_JAL: begin
        next_pc  = jump_target;
        redirect = 1'b1;
        push     = 1'b1;
      end
      SEL_JR: begin
        next_pc  = jr_target;
        redirect = 1'b1;
        pop      = 1'b1;
      end
      default: next_pc = pc_plus;
    endcase
  end

  always_comb begin
    pc_d       = next_pc;
    flush_d    = redirect;
    ras_miss_d = pop && (ras_empty || (ras_mem_q[top_idx] != jr_target));
    ras_mem_d  = ras_mem_q;
    wr_ptr_d   = wr_ptr_q;
    ras_cnt_d  = ras_cnt_q;
    if (push) begin
      // When full, wr_ptr already points at the oldest entry,
      // so a plain write overwrites it.
      ras_mem_d[wr_ptr_q] = pc_plus;
      wr_ptr_d            = wr_ptr_q + PTR_W'(1);
      if (ras_cnt_q != CNT_FULL) begin
        ras_cnt_d = ras_cnt_q + CNT_W'(1);
      end
    end else if (pop && !ras_empty) begin
      wr_ptr_d  = top_idx;
      ras_cnt_d = ras_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      flush_q    <= 1'b0;
      ras_miss_q <= 1'b0;
      wr_ptr_q   <= '0;
      ras_cnt_q  <= '0;
      for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
        ras_mem_q[i] <= '0;
      end
    end else begin
      pc_q       <= pc_d;
      flush_q    <= flush_d;
      ras_miss_q <= ras_miss_d;
      wr_ptr_q   <= wr_ptr_d;
      ras_cnt_q  <= ras_cnt_d;
      for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
        ras_mem_q[i] <= ras_mem_d[i];
      end
    end
  end

  assign pc       = pc_q;
  assign flush    = flush_q;
  assign ras_miss = ras_miss_q;

`ifdef PC_PERF_CNT_EN
  logic [31:0] redirect_count_q, redirect_count_d;
  logic [31:0] ras_miss_count_q, ras_miss_count_d;

  // Each counter advances on the edge that raises its pulse.
  // The count therefore already includes the pulse currently visible.
  always_comb begin
    redirect_count_d = redirect_count_q + {31'd0, redirect};
    ras_miss_count_d = ras_miss_count_q + {31'd0, ras_miss_d};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      redirect_count_q <= '0;
      ras_miss_count_q <= '0;
    end else begin
      redirect_count_q <= redirect_count_d;
      ras_miss_count_q <= ras_miss_count_d;
    end
  end

  assign redirect_count = redirect_count_q;
  assign ras_miss_count = ras_miss_count_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer.
// It runs directed scenarios and then random traffic.
// A queue-based reference model supplies every expected value.
module tb_pc_sequencer;

  localparam int unsigned ADDR_W    = 32;
  localparam logic [31:0] RESET_PC  = 32'h100;
  localparam int unsigned RAS_DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, jal, jump, jr, branch_taken;
  logic [25:0] jump_index;
  logic [31:0] jr_target, branch_offset;
  logic [31:0] pc, pc_plus, next_pc, ras_pred;
  logic        flush, ras_empty, ras_miss;
`ifdef PC_PERF_CNT_EN
  logic [31:0] redirect_count, ras_miss_count;
`endif

  pc_sequencer #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC),
    .RAS_DEPTH(RAS_DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .jal          (jal),
    .jump         (jump),
    .jr           (jr),
    .branch_taken (branch_taken),
    .jump_index   (jump_index),
    .jr_target    (jr_target),
    .branch_offset(branch_offset),
    .pc           (pc),
    .pc_plus      (pc_plus),
    .next_pc      (next_pc),
    .flush        (flush),
    .ras_pred     (ras_pred),
    .ras_empty    (ras_empty),
    .ras_miss     (ras_miss)
`ifdef PC_PERF_CNT_EN
    ,
    .redirect_count(redirect_count),
    .ras_miss_count(ras_miss_count)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference model state.
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  logic        m_flush, m_miss;
  logic [31:0] m_rc, m_mc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc    = RESET_PC;
    m_ras   = {};
    m_flush = 1'b0;
    m_miss  = 1'b0;
    m_rc    = '0;
    m_mc    = '0;
  endtask

  task automatic check_regs(input string ctx);
    check_eq({ctx, ".pc"},       pc,              m_pc);
    check_eq({ctx, ".flush"},    32'(flush),      32'(m_flush));
    check_eq({ctx, ".ras_miss"}, 32'(ras_miss),   32'(m_miss));
`ifdef PC_PERF_CNT_EN
    check_eq({ctx, ".redirect_count"}, redirect_count, m_rc);
    check_eq({ctx, ".ras_miss_count"}, ras_miss_count, m_mc);
`endif
  endtask

  // Apply one cycle of inputs.
  // Check the combinational outputs before the edge and the registered ones after it.
  task automatic step(input logic s, input logic i_jal, input logic i_jump, input logic i_jr,
                      input logic i_br, input logic [25:0] idx, input logic [31:0] tgt,
                      input logic [31:0] off);
    logic [31:0] e_plus, e_next;
    logic        redir;
    @(negedge clk);
    stall = s; jal = i_jal; jump = i_jump; jr = i_jr; branch_taken = i_br;
    jump_index = idx; jr_target = tgt; branch_offset = off;
    #1;
    e_plus = m_pc + 32'd1;
    if (s)           e_next = m_pc;
    else if (i_jr)   e_next = tgt;
    else if (i_jal || i_jump) e_next = {e_plus[31:26], idx};
    else if (i_br)   e_next = e_plus + off;
    else             e_next = e_plus;
    check_eq("pc_plus",   pc_plus,          e_plus);
    check_eq("next_pc",   next_pc,          e_next);
    check_eq("ras_pred",  ras_pred,         (m_ras.size() == 0) ? 32'd0 : m_ras[$]);
    check_eq("ras_empty", 32'(ras_empty),   32'(m_ras.size() == 0));
    @(posedge clk);
    #1;
    redir   = !s && (i_jr || i_jal || i_jump || i_br);
    m_flush = redir;
    m_miss  = !s && i_jr && ((m_ras.size() == 0) || (m_ras[$] != tgt));
    if (!s && i_jr) begin
      if (m_ras.size() > 0) void'(m_ras.pop_back());
    end else if (!s && i_jal) begin
      m_ras.push_back(e_plus);
      if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
    end
    if (redir)  m_rc = m_rc + 32'd1;
    if (m_miss) m_mc = m_mc + 32'd1;
    m_pc = e_next;
    check_regs("post");
  endtask

  task automatic seq_step();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 26'd0, 32'd0, 32'd0);
  endtask

  initial begin
    logic        r_s, r_jal, r_jump, r_jr, r_br;
    logic [31:0] r_tgt;

    reset = 1'b1;
    stall = 0; jal = 0; jump = 0; jr = 0; branch_taken = 0;
    jump_index = '0; jr_target = '0; branch_offset = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_regs("reset");
    check_eq("reset.ras_empty", 32'(ras_empty), 32'd1);
    reset = 1'b0;

    // Sequential counting from RESET_PC.
    repeat (3) seq_step();
    check_eq("seq.pc", pc, 32'h103);

    // Move to 0x10. First try a stalled branch, then a taken branch with offset -4.
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 26'h10, 32'd0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 26'd0, 32'd0, 32'hFFFF_FFFC);
    check_eq("stall.pc", pc, 32'h10);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 26'd0, 32'd0, 32'hFFFF_FFFC);
    check_eq("branch.pc", pc, 32'h0D);
    seq_step();

    // jal from 0x20 to 0x40, then jr back to 0x21 (predicted hit).
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 26'h20, 32'd0, 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 26'h40, 32'd0, 32'd0);
    check_eq("jal.pc", pc, 32'h40);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 26'd0, 32'h21, 32'd0);
    check_eq("jr.pc", pc, 32'h21);

    // jr and jal together: jr wins with no push. The RAS is empty, so this is a miss.
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 26'h3, 32'h55, 32'd0);
    check_eq("jrjal.miss", 32'(ras_miss), 32'd1);
    seq_step();

    // Overfill the RAS and then drain it.
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 26'h0, 32'd0, 32'd0);
    for (int i = 1; i <= 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 26'(i), 32'd0, 32'd0);
    for (int i = 5; i >= 1; i--) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 26'd0, 32'(i), 32'd0);

    // Wrap-around at all-ones.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 26'd0, 32'hFFFF_FFFF, 32'd0);
    seq_step();
    check_eq("wrap.pc", pc, 32'd0);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      r_s    = ($urandom_range(99) < 15);
      r_jr   = ($urandom_range(99) < 15);
      r_jal  = ($urandom_range(99) < 20);
      r_jump = ($urandom_range(99) < 10);
      r_br   = ($urandom_range(99) < 20);
      r_tgt  = ((m_ras.size() > 0) && ($urandom_range(1) == 1)) ? m_ras[$] : $urandom();
      step(r_s, r_jal, r_jump, r_jr, r_br, 26'($urandom()), r_tgt, $urandom());
    end

    // Asynchronous reset applied mid-cycle, right after a redirect.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 26'h77, 32'd0, 32'd0);
    #1;
    reset = 1'b1;
    #1;
    model_reset();
    check_regs("areset");
    check_eq("areset.ras_empty", 32'(ras_empty), 32'd1);
    check_eq("areset.ras_pred",  ras_pred,       32'd0);
    reset = 1'b0;
    seq_step();
    check_eq("after_reset.pc", pc, 32'h101);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
